// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add MUL low word sequenced over the shared ALU
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int IW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [IW-1:0]    iter_inc;
  logic             sr_finish;

  assign iter_inc = iter_q + IW'(1);

  // alu_res during SHR is the shifted multiplier, so a zero means no set bits remain.
`ifdef MUL_EARLY_TERM_EN
  assign sr_finish = (iter_inc == IW'(WIDTH)) || (alu_res == '0);
`else
  assign sr_finish = (iter_inc == IW'(WIDTH));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    result_d = result_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_ADD;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          iter_d   = '0;
`ifdef MUL_EARLY_TERM_EN
          if (op_b == '0) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d = op_b[0] ? S_ADD : S_SHL;
          end
`else
          state_d = op_b[0] ? S_ADD : S_SHL;
`endif
        end
      end
      S_ADD: begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        alu_op  = OP_ADD;
        acc_d   = alu_res;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_a   = mcand_q;
        alu_b   = WIDTH'(1);
        alu_op  = OP_SLL;
        mcand_d = alu_res;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_a    = mplier_q;
        alu_b    = WIDTH'(1);
        alu_op   = OP_SRL;
        mplier_d = alu_res;
        iter_d   = iter_inc;
        if (sr_finish) begin
          state_d  = S_DONE;
          result_d = acc_q;
        end else begin
          state_d = alu_res[0] ? S_ADD : S_SHL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
